// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with fixed-latency valid/ready read and write channels
//
// Ports:
//   clk                    rising-edge clock for all state
//   rst_n                  synchronous active-low reset; zeroes the array, drops pending work
//   rd1_req / rd1_addr     read channel 1 request and address, taken when rd1_ready is high
//   rd1_ready              channel 1 idle
//   rd1_valid / rd1_data   one-cycle completion strobe and held read data
//   rd2_*                  second, fully independent read channel
//   wr_req/wr_addr/wr_data write request, taken when wr_ready is high
//   wr_ready               write channel idle
module reg_file_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int RD_LAT  = 2,
    parameter int WR_LAT  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd1_ready,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              rd2_req,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd2_ready,
    output logic              rd2_valid,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] RD_LOAD  = 2'(RD_LAT);
    localparam logic [1:0] WR_LOAD  = 2'(WR_LAT);
    localparam bit         HAS_ZERO = (ZERO_R0 != 0);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        rd1_cnt;
    logic [1:0]        rd2_cnt;
    logic [1:0]        wr_cnt;
    logic [ADDR_W-1:0] rd1_addr_q;
    logic [ADDR_W-1:0] rd2_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              wr_commit;
    logic              wr_lands;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    // A channel is idle exactly when its countdown has expired.
    assign rd1_ready = (rd1_cnt == 2'd0);
    assign rd2_ready = (rd2_cnt == 2'd0);
    assign wr_ready  = (wr_cnt == 2'd0);

    // Counter at 1 means this edge is the commit edge; a write to R0 still
    // runs its handshake but never reaches the array when R0 is hardwired.
    assign wr_commit = (wr_cnt == 2'd1);
    assign wr_lands  = wr_commit && !(HAS_ZERO && (wr_addr_q == '0));

    // Read value at the completion edge: write-first when a commit to the
    // same address lands on that same edge.
    always_comb begin
        rd1_next = mem[rd1_addr_q];
        if (wr_lands && (wr_addr_q == rd1_addr_q)) begin
            rd1_next = wr_data_q;
        end
        if (HAS_ZERO && (rd1_addr_q == '0)) begin
            rd1_next = '0;
        end
    end

    always_comb begin
        rd2_next = mem[rd2_addr_q];
        if (wr_lands && (wr_addr_q == rd2_addr_q)) begin
            rd2_next = wr_data_q;
        end
        if (HAS_ZERO && (rd2_addr_q == '0)) begin
            rd2_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (wr_lands) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt    <= 2'd0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (wr_cnt != 2'd0) begin
            wr_cnt <= wr_cnt - 2'd1;
        end else if (wr_req) begin
            wr_cnt    <= WR_LOAD;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd1_cnt    <= 2'd0;
            rd1_addr_q <= '0;
            rd1_valid  <= 1'b0;
            rd1_data   <= '0;
        end else begin
            rd1_valid <= 1'b0;
            if (rd1_cnt != 2'd0) begin
                rd1_cnt <= rd1_cnt - 2'd1;
                if (rd1_cnt == 2'd1) begin
                    rd1_valid <= 1'b1;
                    rd1_data  <= rd1_next;
                end
            end else if (rd1_req) begin
                rd1_cnt    <= RD_LOAD;
                rd1_addr_q <= rd1_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd2_cnt    <= 2'd0;
            rd2_addr_q <= '0;
            rd2_valid  <= 1'b0;
            rd2_data   <= '0;
        end else begin
            rd2_valid <= 1'b0;
            if (rd2_cnt != 2'd0) begin
                rd2_cnt <= rd2_cnt - 2'd1;
                if (rd2_cnt == 2'd1) begin
                    rd2_valid <= 1'b1;
                    rd2_data  <= rd2_next;
                end
            end else if (rd2_req) begin
                rd2_cnt    <= RD_LOAD;
                rd2_addr_q <= rd2_addr;
            end
        end
    end
endmodule
